// File: rtl/apb_master.sv
// APB requester: single read/write commands on a valid/ready port,
// sequenced through SETUP/ACCESS with wait states and an optional timeout.
module apb_master #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] LAST =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;
  logic          done;
  logic          abort;

  assign cmd_ready = prst_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SETUP;
      end
      SETUP: begin
        state_nx = ACCESS;
        cnt_nx   = '0;
      end
      ACCESS: begin
        // pready wins over a timeout on the same edge
        if (pready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && cnt == LAST) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (cnt != CMAX) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || abort;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with a behavioural
// APB slave memory and an issue-time reference model.
module tb_apb_master;

  localparam int TO = 4;

  logic        pclk;
  logic        prst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  apb_master #(
    .ADDR_W (6),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
  } cmd_t;

  exp_t        exp_q[$];
  cmd_t        cmd_q[$];
  int          plan_q[$];
  logic [31:0] refmem[64];
  logic [31:0] smem[64];
  int          checks;
  int          errors;
  int          cyc;
  int          last_acc;
  int          acnt;
  int          cur_w;
  cmd_t        cur;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc++;

  assign prdata = smem[paddr];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // slave: memory plus planned wait states, and bus stability checks
  always @(posedge pclk)
    if (prst_n && psel && penable && pready && pwrite)
      smem[paddr] <= pwdata;

  always @(negedge pclk) begin
    if (!prst_n) begin
      acnt   = 0;
      pready = 1'b0;
    end else if (psel && !penable) begin
      chk("setup_expected", 32'(cmd_q.size() != 0), 1);
      if (cmd_q.size() != 0) begin
        cur   = cmd_q.pop_front();
        cur_w = plan_q.pop_front();
        chk("setup_paddr", 32'(paddr), 32'(cur.a));
        chk("setup_pwrite", 32'(pwrite), 32'(cur.w));
        if (cur.w) chk("setup_pwdata", pwdata, cur.d);
      end
      acnt   = 0;
      pready = 1'b0;
    end else if (psel && penable) begin
      chk("access_paddr", 32'(paddr), 32'(cur.a));
      chk("access_pwrite", 32'(pwrite), 32'(cur.w));
      pready = (acnt >= cur_w);
      acnt++;
    end else begin
      pready = 1'b0;
      chk("idle_penable", 32'(penable), 0);
    end
  end

  always @(negedge pclk) begin
    exp_t e;
    if (prst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        chk("rsp_cmd_ready", 32'(cmd_ready), 1);
        chk("rsp_psel", 32'(psel), 0);
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [5:0] a,
                        input logic [31:0] d, input int w);
    int   n;
    int   weff;
    logic err;
    exp_t e;
    n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    err  = (w >= TO);
    weff = err ? TO - 1 : w;
    e.err   = err;
    e.rdata = '0;
    if (!err) begin
      if (wr) refmem[a] = d;
      else    e.rdata = refmem[a];
    end
    last_acc = cyc + 1;
    e.cyc    = last_acc + 2 + weff;
    exp_q.push_back(e);
    cmd_q.push_back('{wr, a, d});
    plan_q.push_back(w);
    @(posedge pclk);
  endtask

  task automatic wait_done(input bit toggle);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge pclk);
      n++;
      if (toggle && !cmd_ready) begin
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 6'($urandom);
        cmd_wdata = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      chk("rsp_wait_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    prst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      refmem[i] = '0;
      smem[i]   = '0;
    end
    repeat (2) @(negedge pclk);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    prst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 1);

    do_cmd(1'b1, 6'h05, 32'hDEADBEEF, 0);
    wait_done(1'b0);
    chk("t1_mem", smem[5], 32'hDEADBEEF);

    do_cmd(1'b0, 6'h05, 32'h0, 3);
    wait_done(1'b1);

    do_cmd(1'b0, 6'h07, 32'h0, 20);
    wait_done(1'b0);

    do_cmd(1'b1, 6'h09, 32'h12345678, TO - 1);
    wait_done(1'b1);
    chk("t6_mem", smem[9], 32'h12345678);

    do_cmd(1'b1, 6'h0A, 32'h1, 0);
    a1 = last_acc;
    do_cmd(1'b0, 6'h0A, 32'h0, 0);
    chk("b2b_gap", 32'(last_acc), 32'(a1 + 3));
    wait_done(1'b0);

    do_cmd(1'b0, 6'h03, 32'h0, 10);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    #2;
    prst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(psel), 0);
    chk("arst_penable", 32'(penable), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_cmd_ready", 32'(cmd_ready), 0);
    exp_q.delete();
    cmd_q.delete();
    plan_q.delete();
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_psel", 32'(psel), 0);
    repeat (8) @(negedge pclk);

    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom), 6'($urandom), $urandom,
             int'($urandom_range(0, TO + 1)));
      if ($urandom_range(0, 2) != 0) wait_done(1'b1);
    end
    wait_done(1'b0);
    repeat (4) @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
